// File: rtl/batcharger_ctrl_gen2_pkg.sv
// Shared state encodings and output decode for the gen2 Li-ion charger controller.
package batcharger_ctrl_gen2_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TC     = 3'd1;
  localparam logic [2:0] ST_CC     = 3'd2;
  localparam logic [2:0] ST_CV     = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_TPAUSE = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  typedef struct packed {
    logic tc;
    logic cc;
    logic cv;
    logic imonen;
    logic vmonen;
    logic tmonen;
    logic done;
    logic fault;
  } out_t;

  function automatic out_t decode_state(input logic [2:0] st);
    out_t o;
    o = '0;
    case (st)
      ST_IDLE:   o = '0;
      ST_TC:     begin o.tc = 1'b1; o.vmonen = 1'b1; o.tmonen = 1'b1; end
      ST_CC:     begin o.cc = 1'b1; o.vmonen = 1'b1; o.tmonen = 1'b1; end
      ST_CV:     begin o.cv = 1'b1; o.imonen = 1'b1; o.vmonen = 1'b1; o.tmonen = 1'b1; end
      ST_DONE:   begin o.done = 1'b1; o.vmonen = 1'b1; o.tmonen = 1'b1; end
      ST_TPAUSE: begin o.vmonen = 1'b1; o.tmonen = 1'b1; end
      ST_FAULT:  o.fault = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/batcharger_ctrl_gen2_timer.sv
// Charge-time supervisor: TICK_DIV prescaler feeding a saturating tick counter.
module batcharger_ctrl_gen2_timer #(
  parameter int TW       = 8,
  parameter int TICK_DIV = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_clear,
  input  logic [TW-1:0] i_tmax,
  output logic          o_expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_ticks;

  // Holding both counters when neither run nor clear is what freezes time during a pause
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pre   <= {PW{1'b0}};
      r_ticks <= {TW{1'b0}};
    end else if (i_run) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= {PW{1'b0}};
        if (r_ticks != {TW{1'b1}}) begin
          r_ticks <= r_ticks + TW'(1);
        end
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  assign o_expired = (i_tmax != {TW{1'b0}}) && (r_ticks == i_tmax);

endmodule

// File: rtl/batcharger_ctrl_gen2.sv
// Gen2 charger controller: TC/CC/CV sequencing, temperature pause, timeout fault, auto-recharge.
module batcharger_ctrl_gen2
  import batcharger_ctrl_gen2_pkg::*;
#(
  parameter int W        = 8,
  parameter int TW       = 8,
  parameter int TICK_DIV = 255,
  parameter int THYST    = 2,
  parameter int VRECH    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_vtok,
  input  logic [W-1:0]  i_vbat,
  input  logic [W-1:0]  i_ibat,
  input  logic [W-1:0]  i_tbat,
  input  logic [W-1:0]  i_vcutoff,
  input  logic [W-1:0]  i_vpreset,
  input  logic [W-1:0]  i_tempmin,
  input  logic [W-1:0]  i_tempmax,
  input  logic [TW-1:0] i_tmax,
  input  logic [W-1:0]  i_iend,
  output logic          o_tc,
  output logic          o_cc,
  output logic          o_cv,
  output logic          o_imonen,
  output logic          o_vmonen,
  output logic          o_tmonen,
  output logic          o_done,
  output logic          o_fault,
  output logic [2:0]    o_state,
  inout  wire           io_dvdd,
  inout  wire           io_dgnd
);

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [2:0] w_eval;
  out_t       r_out;
  logic       w_run, w_clear, w_expired;
  logic       w_temp_out, w_temp_ok, w_recharge;
  logic [W:0] w_tlo, w_thi, w_vrech;
  wire        w_unused_supply = io_dvdd ^ io_dgnd;

  // Hysteresis and recharge thresholds, widened one bit and floored at zero
  always_comb begin
    w_tlo   = {1'b0, i_tempmin} + (W+1)'(THYST);
    w_thi   = {(W+1){1'b0}};
    w_vrech = {(W+1){1'b0}};
    if ({1'b0, i_tempmax} >= (W+1)'(THYST)) begin
      w_thi = {1'b0, i_tempmax} - (W+1)'(THYST);
    end else begin
      w_thi = {(W+1){1'b0}};
    end
    if ({1'b0, i_vpreset} >= (W+1)'(VRECH)) begin
      w_vrech = {1'b0, i_vpreset} - (W+1)'(VRECH);
    end else begin
      w_vrech = {(W+1){1'b0}};
    end
  end

  assign w_temp_out = (i_tbat < i_tempmin) || (i_tbat > i_tempmax);
  assign w_temp_ok  = ({1'b0, i_tbat} >= w_tlo) && ({1'b0, i_tbat} <= w_thi);
  assign w_recharge = ({1'b0, i_vbat} < w_vrech);

  // Entry decision shared by IDLE start, pause resume and recharge
  always_comb begin
    w_eval = ST_CC;
    if (w_temp_out) begin
      w_eval = ST_TPAUSE;
    end else if (i_vbat >= i_vpreset) begin
      w_eval = ST_DONE;
    end else if (i_vbat < i_vcutoff) begin
      w_eval = ST_TC;
    end else begin
      w_eval = ST_CC;
    end
  end

  // Timer runs only while charging; TPAUSE is neither run nor clear so the count holds
  always_comb begin
    w_run   = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_TC, ST_CC, ST_CV: w_run   = 1'b1;
      ST_TPAUSE:           w_run   = 1'b0;
      default:             w_clear = 1'b1;
    endcase
  end

  batcharger_ctrl_gen2_timer #(
    .TW       (TW),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (w_run),
    .i_clear   (w_clear),
    .i_tmax    (i_tmax),
    .o_expired (w_expired)
  );

  // Next state; loss of vtok alone must not release a latched fault
  always_comb begin
    w_state_next = r_state;
    if (!i_en) begin
      w_state_next = ST_IDLE;
    end else if (!i_vtok) begin
      w_state_next = (r_state == ST_FAULT) ? ST_FAULT : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = w_eval;
        ST_TC, ST_CC, ST_CV: begin
          if (w_temp_out) begin
            w_state_next = ST_TPAUSE;
          end else if (w_expired) begin
            w_state_next = (r_state == ST_CV) ? ST_DONE : ST_FAULT;
          end else if ((r_state == ST_TC) && (i_vbat >= i_vcutoff)) begin
            w_state_next = ST_CC;
          end else if ((r_state == ST_CC) && (i_vbat >= i_vpreset)) begin
            w_state_next = ST_CV;
          end else if ((r_state == ST_CV) && (i_ibat < i_iend)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = r_state;
          end
        end
        ST_TPAUSE: w_state_next = w_temp_ok ? w_eval : ST_TPAUSE;
        ST_DONE:   w_state_next = w_recharge ? w_eval : ST_DONE;
        ST_FAULT:  w_state_next = ST_FAULT;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they move on the same edge as the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      r_out   <= decode_state(w_state_next);
    end
  end

  assign o_tc     = r_out.tc;
  assign o_cc     = r_out.cc;
  assign o_cv     = r_out.cv;
  assign o_imonen = r_out.imonen;
  assign o_vmonen = r_out.vmonen;
  assign o_tmonen = r_out.tmonen;
  assign o_done   = r_out.done;
  assign o_fault  = r_out.fault;
  assign o_state  = r_state;

endmodule
